piso_tx: RTL and testbench

Parallel-in, serial-out framed transmitter for the CDC example design. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line. Each frame is a start bit, then the data LSB-first, then an even-parity bit. It is the source end of the serial path: its `dout` drives the serial delay line and the downstream receiver.

---
 rtl/piso_tx_pkg.sv | 14 +
 rtl/piso_tx_if.sv | 21 ++
 rtl/piso_hold_buf.sv | 30 +++
 rtl/piso_tx.sv | 109 ++++++++++
 tb/tb_piso_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the piso_tx serial transmitter and its consumers.
package piso_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, PARITY} piso_state_t;

    localparam logic PISO_IDLE_LEVEL  = 1'b0;
    localparam logic PISO_START_LEVEL = 1'b1;

    // Line cycles per frame: start bit, data bits, parity bit.
    function automatic int piso_frame_len(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Parallel handshake plus serial line outputs of piso_tx; slave is the transmitter side.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             sof;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, dout, sof, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, sof, busy
    );
endinterface

// File: rtl/piso_hold_buf.sv
// One-entry holding register that buffers the next word while a frame is on the line.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             vld,
    output logic             ready
);
    logic [WIDTH-1:0] data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            data <= wdata;
            vld  <= 1'b1;
        end else if (rd) begin
            vld  <= 1'b0;
        end
    end

    assign rdata = data;
    assign ready = !vld;
endmodule

// File: rtl/piso_tx.sv
// Framed parallel-to-serial transmitter: start bit, LSB-first data, even parity.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    piso_tx_if.slave  bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_data;
    logic [CNT_W-1:0] cnt;
    logic             par;
    logic             dout_r;
    logic             sof_r;
    logic             hold_vld;
    logic             ready;
    logic             xfer;
    logic             hold_wr;
    logic             hold_rd;

    assign xfer    = bus.din_valid && ready;
    assign hold_rd = (state == PARITY) && hold_vld;
    // In PARITY with an empty hold the new word bypasses hold and starts the next frame directly.
    assign hold_wr = xfer && ((state == START) || (state == DATA));

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .reset (reset),
        .wr    (hold_wr),
        .rd    (hold_rd),
        .wdata (bus.din),
        .rdata (hold_data),
        .vld   (hold_vld),
        .ready (ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            par    <= 1'b0;
            dout_r <= PISO_IDLE_LEVEL;
            sof_r  <= 1'b0;
        end else begin
            sof_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg  <= bus.din;
                        par    <= ^bus.din;
                        dout_r <= PISO_START_LEVEL;
                        sof_r  <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    cnt    <= '0;
                    dout_r <= shreg[0];
                    shreg  <= shreg >> 1;
                    state  <= DATA;
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        dout_r <= par;
                        state  <= PARITY;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        dout_r <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
                PARITY: begin
                    if (hold_vld) begin
                        shreg  <= hold_data;
                        par    <= ^hold_data;
                        dout_r <= PISO_START_LEVEL;
                        sof_r  <= 1'b1;
                        state  <= START;
                    end else if (xfer) begin
                        shreg  <= bus.din;
                        par    <= ^bus.din;
                        dout_r <= PISO_START_LEVEL;
                        sof_r  <= 1'b1;
                        state  <= START;
                    end else begin
                        dout_r <= PISO_IDLE_LEVEL;
                        state  <= IDLE;
                    end
                end
                default: begin
                    dout_r <= PISO_IDLE_LEVEL;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout      = dout_r;
    assign bus.sof       = sof_r;
    assign bus.busy      = (state != IDLE);
    assign bus.din_ready = ready;
endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx at WIDTH 8, 2 and 32 sharing one clock and reset.
module tb_piso_tx;
    import piso_tx_pkg::*;

    localparam int WID [3] = '{8, 2, 32};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(8))  bus8 ();
    piso_tx_if #(.WIDTH(2))  bus2 ();
    piso_tx_if #(.WIDTH(32)) bus32 ();

    piso_tx #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    piso_tx #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));
    piso_tx #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

    logic [31:0] din_a   [3];
    logic        valid_a [3];
    logic        dout_a  [3];
    logic        sof_a   [3];
    logic        busy_a  [3];
    logic        ready_a [3];

    assign bus8.din        = din_a[0][7:0];
    assign bus2.din        = din_a[1][1:0];
    assign bus32.din       = din_a[2];
    assign bus8.din_valid  = valid_a[0];
    assign bus2.din_valid  = valid_a[1];
    assign bus32.din_valid = valid_a[2];
    assign dout_a[0]  = bus8.dout;
    assign dout_a[1]  = bus2.dout;
    assign dout_a[2]  = bus32.dout;
    assign sof_a[0]   = bus8.sof;
    assign sof_a[1]   = bus2.sof;
    assign sof_a[2]   = bus32.sof;
    assign busy_a[0]  = bus8.busy;
    assign busy_a[1]  = bus2.busy;
    assign busy_a[2]  = bus32.busy;
    assign ready_a[0] = bus8.din_ready;
    assign ready_a[1] = bus2.din_ready;
    assign ready_a[2] = bus32.din_ready;

    logic [31:0] exp_q [3][$];
    int frames [3] = '{0, 0, 0};
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_w(input int k, input logic [31:0] w);
        if (WID[k] == 32) return w;
        return w & ((32'd1 << WID[k]) - 32'd1);
    endfunction

    // Frame monitors: deserialize each frame and pop the expected word when its parity bit arrives.
    for (genvar k = 0; k < 3; k++) begin : g_mon
        int          pos = -1;
        logic [31:0] data;
        logic [31:0] expw;
        logic        ctl_ok;
        always @(negedge clk) begin
            if (reset) begin
                pos = -1;
            end else if (pos < 0) begin
                if (sof_a[k]) begin
                    pos    = 0;
                    data   = '0;
                    ctl_ok = (dout_a[k] == PISO_START_LEVEL) && busy_a[k];
                end
            end else if (pos < WID[k]) begin
                data[pos] = dout_a[k];
                ctl_ok    = ctl_ok && !sof_a[k] && busy_a[k];
                pos++;
            end else begin
                ctl_ok = ctl_ok && !sof_a[k] && busy_a[k];
                frames[k]++;
                chk($sformatf("frame_ctl[w%0d]", WID[k]), 64'(ctl_ok), 64'd1);
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame[w%0d]: got data %0h, expected no frame", WID[k], data);
                end else begin
                    expw = exp_q[k].pop_front();
                    chk($sformatf("frame_data[w%0d]", WID[k]), 64'(data), 64'(expw));
                    chk($sformatf("frame_parity[w%0d]", WID[k]), 64'(dout_a[k]), 64'(^expw));
                end
                pos = -1;
            end
        end
    end

    // Presents a word and returns #1 after the edge that accepts it; valid is left asserted.
    task automatic send(input int k, input logic [31:0] w);
        int  n = 0;
        bit  done = 0;
        din_a[k]   = w;
        valid_a[k] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_a[k]) begin
                @(posedge clk);
                #1;
                exp_q[k].push_back(mask_w(k, w));
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout[w%0d]: got no accept in %0d cycles, expected accept", WID[k], n);
                    done = 1;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 ||
                busy_a[0] || busy_a[1] || busy_a[2]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 5000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic frame_len(input int k, input logic [31:0] w);
        int n = 0;
        send(k, w);
        valid_a[k] = 1'b0;
        @(negedge clk);
        while (busy_a[k] && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("frame_len[w%0d]", WID[k]), 64'(n), 64'(piso_frame_len(WID[k])));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0]  seq;
        logic [9:0]  sofs;
        int          nbusy;
        int          n;
        int          f0;
        logic        prev;
        logic        quiet;
        logic [31:0] w32 [5];

        for (int k = 0; k < 3; k++) begin
            din_a[k]   = '0;
            valid_a[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state[w%0d]", WID[k]),
                64'({dout_a[k], sof_a[k], busy_a[k], ready_a[k]}), 64'b0001);
        reset = 1'b0;

        // Single word 8'hA5: exact line sequence, sof and busy duration.
        send(0, 32'hA5);
        valid_a[0] = 1'b0;
        seq   = '0;
        sofs  = '0;
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq[i]  = dout_a[0];
            sofs[i] = sof_a[0];
            nbusy  += int'(busy_a[0]);
        end
        @(negedge clk);
        chk("a5_dout_seq", 64'(seq), 64'(10'b0101001011));
        chk("a5_sof_seq", 64'(sofs), 64'(10'b0000000001));
        chk("a5_busy_cycles", 64'(nbusy), 64'd10);
        chk("a5_idle_after", 64'({busy_a[0], dout_a[0]}), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back 8'h01 then 8'h03: ready low until the second START, no gap after parity.
        send(0, 32'h01);
        send(0, 32'h03);
        valid_a[0] = 1'b0;
        n = 0;
        prev = 1'b0;
        @(negedge clk);
        while (!ready_a[0] && n < 50) begin
            prev = dout_a[0];
            n++;
            @(negedge clk);
        end
        chk("b2b_ready_low_cycles", 64'(n), 64'd9);
        chk("b2b_prev_parity", 64'(prev), 64'd1);
        chk("b2b_second_sof", 64'({sof_a[0], dout_a[0]}), 64'b11);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: four words with valid held high.
        f0 = frames[0];
        send(0, 32'h11);
        send(0, 32'h22);
        send(0, 32'h33);
        send(0, 32'h44);
        valid_a[0] = 1'b0;
        drain();
        chk("bp_frame_count", 64'(frames[0] - f0), 64'd4);

        // Reset during data bit 3 with a word held: held word must never appear.
        send(0, 32'h3C);
        send(0, 32'hC3);
        valid_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy_held", 64'({busy_a[0], ready_a[0]}), 64'b10);
        f0 = frames[0];
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({dout_a[0], sof_a[0], busy_a[0], ready_a[0]}), 64'b0001);
        exp_q[0].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            quiet = quiet && !dout_a[0] && !busy_a[0] && !sof_a[0];
        end
        chk("post_reset_line_idle", 64'(quiet), 64'd1);
        chk("post_reset_no_frames", 64'(frames[0] - f0), 64'd0);
        @(posedge clk);
        #1;

        // Parity sweep over all byte values, streamed back-to-back.
        f0 = frames[0];
        for (int v = 0; v < 256; v++) send(0, 32'(v));
        valid_a[0] = 1'b0;
        drain();
        chk("sweep8_frame_count", 64'(frames[0] - f0), 64'd256);

        // Narrow and wide widths: frame lengths, counter wrap, parity.
        frame_len(1, 32'h2);
        frame_len(2, 32'h8000_0001);
        for (int v = 0; v < 4; v++) send(1, 32'(v));
        valid_a[1] = 1'b0;
        w32 = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001};
        for (int i = 0; i < 5; i++) send(2, w32[i]);
        valid_a[2] = 1'b0;
        drain();

        for (int k = 0; k < 3; k++)
            chk($sformatf("queue_empty[w%0d]", WID[k]), 64'(exp_q[k].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
